// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for LDM/STM: walks the register list one beat per
// cycle, emitting register number and word address, then the base writeback.
module ldm_stm_sequencer #(
   parameter int AW   = 32,
   parameter int NREG = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [NREG-1:0]           reg_list,
   input  logic [AW-1:0]             base_addr,
   input  logic                      up,
   input  logic                      pre,
   input  logic                      wback,
   input  logic                      is_load,
   input  logic                      hold,
   output logic                      busy,
   output logic                      stall_dec,
   output logic                      mem_valid,
   output logic                      mem_we,
   output logic [$clog2(NREG)-1:0]   reg_addr,
   output logic [AW-1:0]             mem_addr,
   output logic                      last,
   output logic                      wb_valid,
   output logic [AW-1:0]             wb_data,
   output logic                      done
);

   localparam int RW = $clog2(NREG);
   localparam int CW = $clog2(NREG + 1);

   typedef enum logic [1:0] {IDLE, XFER, WBACK, DONE} state_t;

   state_t            state_p0, state_nx;
   logic [NREG-1:0]   list_p0, list_nx;
   logic [AW-1:0]     addr_p0, addr_nx;
   logic [AW-1:0]     wbv_p0, wbv_nx;
   logic              wback_p0, wback_nx;
   logic              we_p0, we_nx;
   logic [CW-1:0]     cnt;
   logic [AW-1:0]     span;

   logic              mem_valid_nx, mem_we_nx, last_nx, wb_valid_nx, done_nx, busy_nx;
   logic [RW-1:0]     reg_addr_nx;
   logic [AW-1:0]     mem_addr_nx, wb_data_nx;

   function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   function automatic logic [RW-1:0] lowest_bit(input logic [NREG-1:0] v);
      logic [RW-1:0] idx;
      idx = '0;
      for (int i = NREG - 1; i >= 0; i--) if (v[i]) idx = RW'(i);
      return idx;
   endfunction

   function automatic logic one_left(input logic [NREG-1:0] v);
      return (v != '0) && ((v & (v - NREG'(1))) == '0);
   endfunction

   assign stall_dec = busy | start;

   // Transfers always run upward from the lowest address; decrement modes
   // only move the starting point down by the block size.
   always_comb begin
      state_nx = state_p0;
      list_nx  = list_p0;
      addr_nx  = addr_p0;
      wbv_nx   = wbv_p0;
      wback_nx = wback_p0;
      we_nx    = we_p0;
      cnt      = popcount(reg_list);
      span     = AW'(cnt) << 2;
      case (state_p0)
         IDLE: begin
            if (start) begin
               list_nx  = reg_list;
               wback_nx = wback;
               we_nx    = ~is_load;
               if (up) addr_nx = pre ? base_addr + AW'(4) : base_addr;
               else    addr_nx = pre ? base_addr - span : base_addr - span + AW'(4);
               wbv_nx   = up ? base_addr + span : base_addr - span;
               if (cnt != '0)  state_nx = XFER;
               else if (wback) state_nx = WBACK;
               else            state_nx = DONE;
            end
         end
         XFER: begin
            if (!hold) begin
               list_nx = list_p0 & (list_p0 - NREG'(1));
               addr_nx = addr_p0 + AW'(4);
               if (one_left(list_p0)) state_nx = wback_p0 ? WBACK : DONE;
            end
         end
         WBACK: if (!hold) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are precomputed from the next state so they leave a flop.
   always_comb begin
      mem_valid_nx = 1'b0;
      mem_we_nx    = 1'b0;
      reg_addr_nx  = '0;
      mem_addr_nx  = '0;
      last_nx      = 1'b0;
      wb_valid_nx  = 1'b0;
      wb_data_nx   = '0;
      done_nx      = 1'b0;
      busy_nx      = (state_nx != IDLE);
      case (state_nx)
         XFER: begin
            mem_valid_nx = 1'b1;
            mem_we_nx    = we_nx;
            reg_addr_nx  = lowest_bit(list_nx);
            mem_addr_nx  = addr_nx;
            last_nx      = one_left(list_nx);
         end
         WBACK: begin
            wb_valid_nx = 1'b1;
            wb_data_nx  = wbv_nx;
         end
         DONE:    done_nx = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p0  <= IDLE;
         list_p0   <= '0;
         addr_p0   <= '0;
         wbv_p0    <= '0;
         wback_p0  <= 1'b0;
         we_p0     <= 1'b0;
         busy      <= 1'b0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         reg_addr  <= '0;
         mem_addr  <= '0;
         last      <= 1'b0;
         wb_valid  <= 1'b0;
         wb_data   <= '0;
         done      <= 1'b0;
      end else begin
         state_p0  <= state_nx;
         list_p0   <= list_nx;
         addr_p0   <= addr_nx;
         wbv_p0    <= wbv_nx;
         wback_p0  <= wback_nx;
         we_p0     <= we_nx;
         busy      <= busy_nx;
         mem_valid <= mem_valid_nx;
         mem_we    <= mem_we_nx;
         reg_addr  <= reg_addr_nx;
         mem_addr  <= mem_addr_nx;
         last      <= last_nx;
         wb_valid  <= wb_valid_nx;
         wb_data   <= wb_data_nx;
         done      <= done_nx;
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized bench for ldm_stm_sequencer against a queue-based model of the
// expected beat / writeback / done sequence for each block transfer.
module tb_ldm_stm_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] reg_list;
   logic [31:0] base_addr;
   logic        up, pre, wback, is_load, hold;
   logic        busy, stall_dec, mem_valid, mem_we, last, wb_valid, done;
   logic [3:0]  reg_addr;
   logic [31:0] mem_addr, wb_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ldm_stm_sequencer #(.AW(32), .NREG(16)) dut (
      .clk(clk), .rst(rst), .start(start), .reg_list(reg_list),
      .base_addr(base_addr), .up(up), .pre(pre), .wback(wback),
      .is_load(is_load), .hold(hold), .busy(busy), .stall_dec(stall_dec),
      .mem_valid(mem_valid), .mem_we(mem_we), .reg_addr(reg_addr),
      .mem_addr(mem_addr), .last(last), .wb_valid(wb_valid),
      .wb_data(wb_data), .done(done)
   );

   typedef struct {
      int          kind;   // 0 beat, 1 writeback, 2 done
      logic [3:0]  r;
      logic [31:0] a;
      logic        l;
   } ev_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_mv"},   mem_valid, 0);
      check({tag, "_wbv"},  wb_valid, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_radr"}, reg_addr, 0);
      check({tag, "_madr"}, mem_addr, 0);
      check({tag, "_wbd"},  wb_data, 0);
      check({tag, "_last"}, last, 0);
      check({tag, "_we"},   mem_we, 0);
   endtask

   // hmode: 0 never hold, 1 random hold, 2 hold second beat for two cycles
   task automatic run_txn(input logic [15:0] lst, input logic [31:0] base,
                          input bit u, input bit p, input bit w, input bit ld,
                          input int hmode);
      ev_t         q[$];
      ev_t         e;
      int          n, k, idx, held, cyc;
      logic [31:0] lo, wbv;
      n = 0;
      for (int i = 0; i < 16; i++) if (lst[i]) n++;
      lo  = u ? (p ? base + 32'd4 : base)
              : (p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4);
      wbv = u ? base + 32'(4 * n) : base - 32'(4 * n);
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (lst[i]) begin
            e.kind = 0; e.r = i[3:0]; e.a = lo + 32'(4 * k);
            k++;
            e.l = (k == n);
            q.push_back(e);
         end
      end
      if (w) begin e.kind = 1; e.r = 0; e.a = wbv; e.l = 0; q.push_back(e); end
      e.kind = 2; e.r = 0; e.a = 0; e.l = 0; q.push_back(e);

      @(negedge clk);
      reg_list = lst; base_addr = base; up = u; pre = p; wback = w;
      is_load = ld; start = 1'b1; hold = 1'b0;
      #1;
      check("idle_before_start", busy, 0);
      check("stall_on_start", stall_dec, 1);

      idx = 0; held = 0; cyc = 0;
      while (q.size() > 0 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         e = q[0];
         check("busy", busy, 1);
         case (e.kind)
            0: begin
               check("beat_mv", mem_valid, 1);
               check("beat_reg", reg_addr, e.r);
               check("beat_addr", mem_addr, e.a);
               check("beat_last", last, e.l);
               check("beat_we", mem_we, !ld);
               check("beat_wbv", wb_valid, 0);
               check("beat_done", done, 0);
            end
            1: begin
               check("wb_valid", wb_valid, 1);
               check("wb_data", wb_data, e.a);
               check("wb_reg", reg_addr, 0);
               check("wb_mv", mem_valid, 0);
               check("wb_done", done, 0);
            end
            default: begin
               check("done", done, 1);
               check("done_mv", mem_valid, 0);
               check("done_wbv", wb_valid, 0);
            end
         endcase
         // noise on decode inputs while busy; must all be ignored
         start     = ($urandom_range(0, 2) == 0);
         reg_list  = 16'($urandom);
         base_addr = $urandom;
         up = 1'($urandom); pre = 1'($urandom);
         wback = 1'($urandom); is_load = 1'($urandom);
         if (e.kind == 2)      hold = 1'b0;
         else if (hmode == 1)  hold = ($urandom_range(0, 3) == 0);
         else if (hmode == 2)  hold = (idx == 1 && held < 2);
         else                  hold = 1'b0;
         #1;
         check("stall_busy", stall_dec, 1);
         if (!hold) begin
            void'(q.pop_front());
            idx++;
            held = 0;
         end else begin
            held++;
         end
      end
      if (q.size() != 0) check("txn_timeout", 32'(q.size()), 0);
      @(negedge clk);
      start = 1'b0; hold = 1'b0;
      #1;
      check_idle("after_done");
      check("stall_idle", stall_dec, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0;
      up = 1'b0; pre = 1'b0; wback = 1'b0; is_load = 1'b0; hold = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("reset_stall", stall_dec, 0);
      rst = 1'b0;

      // IA load with writeback
      run_txn(16'h000B, 32'h100, 1, 0, 1, 1, 0);
      // DB store, no writeback
      run_txn(16'h8001, 32'h200, 0, 1, 0, 0, 0);
      // hold on second beat
      run_txn(16'h0007, 32'h40, 1, 0, 0, 1, 2);
      // empty list with writeback, and without
      run_txn(16'h0000, 32'h80, 1, 0, 1, 1, 0);
      run_txn(16'h0000, 32'h80, 0, 1, 0, 0, 0);
      // full list wrapping around the top of the address space
      run_txn(16'hFFFF, 32'hFFFFFFF8, 1, 0, 1, 1, 0);
      // IB and DA
      run_txn(16'h00F0, 32'h1000, 1, 1, 1, 0, 0);
      run_txn(16'h0C03, 32'h1000, 0, 0, 1, 1, 1);

      // asynchronous reset in the middle of a transfer
      @(negedge clk);
      reg_list = 16'h000F; base_addr = 32'h1000; up = 1; pre = 0;
      wback = 1; is_load = 1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rst_beat1_reg", reg_addr, 0);
      @(negedge clk);
      check("rst_beat2_reg", reg_addr, 1);
      check("rst_beat2_addr", mem_addr, 32'h1004);
      rst = 1'b1;
      #1;
      check_idle("async_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("post_rst");

      for (int t = 0; t < 40; t++) begin
         logic [15:0] l;
         l = 16'($urandom);
         if (t % 5 == 0) l = l & 16'($urandom);
         if (t % 13 == 0) l = '0;
         run_txn(l, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
